// File: rtl/output_bus_receiver.sv
// Pixel output bus receiver: rebuilds rows from strobed beats
// and presents them to a consumer over valid/ready.
module output_bus_receiver #(
  parameter int PIXEL_ARRAY_WIDTH  = 8,
  parameter int PIXEL_ARRAY_HEIGHT = 8,
  parameter int OUTPUT_BUS_WIDTH   = 2,
  parameter int PIXEL_BITS         = 8,
  localparam int BEATS     = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int ROW_BITS  = (PIXEL_ARRAY_HEIGHT > 1) ?
                             $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int BEAT_W    = OUTPUT_BUS_WIDTH * PIXEL_BITS,
  localparam int ROW_W     = PIXEL_ARRAY_WIDTH * PIXEL_BITS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BUS_STROBE,
  input  logic [BEAT_W-1:0]   BUS_DATA,
  output logic [ROW_W-1:0]    ROW_DATA,
  output logic                ROW_VALID,
  input  logic                ROW_READY,
  output logic [ROW_BITS-1:0] ROW_INDEX,
  output logic                FRAME_END,
  output logic                OVERFLOW,
  output logic                SHORT_ERR,
  input  logic                CLEAR_ERR
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t r_state;
  state_t w_next;

  logic [BEAT_BITS-1:0] r_beat_cnt;
  logic [ROW_BITS-1:0]  r_row_cnt;
  logic [ROW_W-1:0]     r_buf;
  logic [ROW_W-1:0]     r_row_data;
  logic                 r_row_valid;
  logic [ROW_BITS-1:0]  r_row_index;
  logic                 r_frame_end;
  logic                 r_overflow;
  logic                 r_short_err;

  logic [ROW_W-1:0] w_row;
  logic             w_last;
  logic             w_accept;
  logic             w_load;
  logic             w_drop;
  logic             w_short;
  logic             w_row_wrap;

  // Buffer with the current beat merged in, so completion needs no extra cycle
  always_comb begin
    w_row = r_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (BEAT_BITS'(b) == r_beat_cnt)
        w_row[b*BEAT_W +: BEAT_W] = BUS_DATA;
    end
  end

  assign w_last     = BUS_STROBE &&
                      (r_beat_cnt == BEAT_BITS'(BEATS - 1));
  assign w_accept   = r_row_valid && ROW_READY;
  assign w_load     = w_last && (!r_row_valid || w_accept);
  assign w_drop     = w_last && !w_load;
  assign w_short    = (r_state == RECV) && !BUS_STROBE;
  assign w_row_wrap = (r_row_cnt ==
                       ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE: if (BUS_STROBE && !w_last) w_next = RECV;
      RECV: if (BUS_STROBE && !w_last) w_next = RECV;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_beat_cnt  <= '0;
      r_row_cnt   <= '0;
      r_buf       <= '0;
      r_row_data  <= '0;
      r_row_valid <= 1'b0;
      r_row_index <= '0;
      r_frame_end <= 1'b0;
      r_overflow  <= 1'b0;
      r_short_err <= 1'b0;
    end else begin
      if (BUS_STROBE) begin
        r_buf      <= w_row;
        r_beat_cnt <= w_last ? '0
                             : r_beat_cnt + BEAT_BITS'(1);
      end else begin
        r_beat_cnt <= '0;
      end

      // Dropped rows still advance the count to keep frame alignment
      if (w_last)
        r_row_cnt <= w_row_wrap ? '0
                                : r_row_cnt + ROW_BITS'(1);

      if (w_load) begin
        r_row_data  <= w_row;
        r_row_index <= r_row_cnt;
        r_frame_end <= w_row_wrap;
        r_row_valid <= 1'b1;
      end else if (w_accept) begin
        r_row_valid <= 1'b0;
      end

      if (w_drop)
        r_overflow <= 1'b1;
      else if (CLEAR_ERR)
        r_overflow <= 1'b0;

      if (w_short)
        r_short_err <= 1'b1;
      else if (CLEAR_ERR)
        r_short_err <= 1'b0;
    end
  end

  assign ROW_DATA  = r_row_data;
  assign ROW_VALID = r_row_valid;
  assign ROW_INDEX = r_row_index;
  assign FRAME_END = r_frame_end;
  assign OVERFLOW  = r_overflow;
  assign SHORT_ERR = r_short_err;

endmodule

// File: tb/tb_output_bus_receiver.sv
// Directed bench for output_bus_receiver with default parameters
// (8x8 array, 2 pixels per beat, 4 beats per row).
module tb_output_bus_receiver;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUS_STROBE;
  logic [15:0] BUS_DATA;
  logic [63:0] ROW_DATA;
  logic        ROW_VALID;
  logic        ROW_READY;
  logic [2:0]  ROW_INDEX;
  logic        FRAME_END;
  logic        OVERFLOW;
  logic        SHORT_ERR;
  logic        CLEAR_ERR;

  int errors = 0;
  int checks = 0;

  output_bus_receiver dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BUS_STROBE (BUS_STROBE),
    .BUS_DATA   (BUS_DATA),
    .ROW_DATA   (ROW_DATA),
    .ROW_VALID  (ROW_VALID),
    .ROW_READY  (ROW_READY),
    .ROW_INDEX  (ROW_INDEX),
    .FRAME_END  (FRAME_END),
    .OVERFLOW   (OVERFLOW),
    .SHORT_ERR  (SHORT_ERR),
    .CLEAR_ERR  (CLEAR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat n of row k carries pixels k*8+2n and k*8+2n+1
  function automatic logic [15:0] bt(input int k, input int n);
    logic [7:0] p0;
    logic [7:0] p1;
    p0 = 8'(k*8 + 2*n);
    p1 = 8'(k*8 + 2*n + 1);
    return {p1, p0};
  endfunction

  function automatic logic [63:0] mkrow(input int k);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < 8; p++) r[p*8 +: 8] = 8'(k*8 + p);
    return r;
  endfunction

  task automatic beat(input logic [15:0] d);
    BUS_STROBE = 1'b1;
    BUS_DATA   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    BUS_STROBE = 1'b0;
    BUS_DATA   = '0;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_row(input int k);
    for (int n = 0; n < 4; n++) beat(bt(k, n));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(ROW_VALID), 64'd0);
    chk({tag, "_data"},  ROW_DATA,       64'd0);
    chk({tag, "_index"}, 64'(ROW_INDEX), 64'd0);
    chk({tag, "_fend"},  64'(FRAME_END), 64'd0);
    chk({tag, "_ovf"},   64'(OVERFLOW),  64'd0);
    chk({tag, "_short"}, 64'(SHORT_ERR), 64'd0);
  endtask

  initial begin
    RESET      = 1'b1;
    BUS_STROBE = 1'b0;
    BUS_DATA   = '0;
    ROW_READY  = 1'b0;
    CLEAR_ERR  = 1'b0;
    #1;
    chk_zero("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // 1: single row, latency and pixel placement
    ROW_READY = 1'b1;
    beat(bt(0, 0));
    beat(bt(0, 1));
    beat(bt(0, 2));
    chk("t1_no_partial", 64'(ROW_VALID), 64'd0);
    beat(bt(0, 3));
    BUS_STROBE = 1'b0;
    chk("t1_valid", 64'(ROW_VALID), 64'd1);
    chk("t1_data",  ROW_DATA, 64'h0706050403020100);
    chk("t1_index", 64'(ROW_INDEX), 64'd0);
    chk("t1_fend",  64'(FRAME_END), 64'd0);
    idle();
    chk("t1_accepted", 64'(ROW_VALID), 64'd0);

    // 2: a frame plus one row, strobe held continuously
    do_reset();
    for (int i = 0; i < 36; i++) begin
      beat(bt(i/4, i%4));
      if (i % 4 == 3) begin
        chk("t2_valid", 64'(ROW_VALID), 64'd1);
        chk("t2_index", 64'(ROW_INDEX), 64'((i/4) % 8));
        chk("t2_fend",  64'(FRAME_END), 64'((i/4) == 7));
        chk("t2_data",  ROW_DATA, mkrow(i/4));
      end else begin
        chk("t2_gap", 64'(ROW_VALID), 64'd0);
      end
    end
    idle();

    // 3: stalled consumer, second row dropped
    do_reset();
    ROW_READY = 1'b0;
    send_row(0);
    chk("t3_valid_a", 64'(ROW_VALID), 64'd1);
    for (int n = 0; n < 4; n++) begin
      beat(bt(1, n));
      chk("t3_hold_data", ROW_DATA, mkrow(0));
      chk("t3_hold_valid", 64'(ROW_VALID), 64'd1);
    end
    BUS_STROBE = 1'b0;
    chk("t3_ovf", 64'(OVERFLOW), 64'd1);
    chk("t3_hold_index", 64'(ROW_INDEX), 64'd0);
    ROW_READY = 1'b1;
    idle();
    chk("t3_accept", 64'(ROW_VALID), 64'd0);
    send_row(2);
    BUS_STROBE = 1'b0;
    chk("t3_c_valid", 64'(ROW_VALID), 64'd1);
    chk("t3_c_index", 64'(ROW_INDEX), 64'd2);
    chk("t3_c_data",  ROW_DATA, mkrow(2));
    idle();

    // 4: short bursts and error clearing
    CLEAR_ERR = 1'b1;
    idle();
    CLEAR_ERR = 1'b0;
    chk("t4_ovf_clr", 64'(OVERFLOW), 64'd0);
    beat(bt(9, 0));
    beat(bt(9, 1));
    idle();
    chk("t4_short", 64'(SHORT_ERR), 64'd1);
    chk("t4_no_row", 64'(ROW_VALID), 64'd0);
    send_row(3);
    BUS_STROBE = 1'b0;
    chk("t4_valid", 64'(ROW_VALID), 64'd1);
    chk("t4_index", 64'(ROW_INDEX), 64'd3);
    chk("t4_data",  ROW_DATA, mkrow(3));
    idle();
    beat(bt(9, 0));
    CLEAR_ERR = 1'b1;
    idle();
    CLEAR_ERR = 1'b0;
    chk("t4_err_wins", 64'(SHORT_ERR), 64'd1);
    CLEAR_ERR = 1'b1;
    idle();
    CLEAR_ERR = 1'b0;
    chk("t4_short_clr", 64'(SHORT_ERR), 64'd0);

    // 5: accept and load on the same edge
    ROW_READY = 1'b0;
    send_row(4);
    BUS_STROBE = 1'b0;
    chk("t5_first", 64'(ROW_INDEX), 64'd4);
    idle();
    beat(bt(5, 0));
    beat(bt(5, 1));
    beat(bt(5, 2));
    ROW_READY = 1'b1;
    beat(bt(5, 3));
    BUS_STROBE = 1'b0;
    chk("t5_valid", 64'(ROW_VALID), 64'd1);
    chk("t5_index", 64'(ROW_INDEX), 64'd5);
    chk("t5_data",  ROW_DATA, mkrow(5));
    chk("t5_ovf",   64'(OVERFLOW), 64'd0);
    idle();
    chk("t5_drain", 64'(ROW_VALID), 64'd0);

    // 6: async reset mid-burst while a row is held
    ROW_READY = 1'b0;
    send_row(6);
    beat(bt(9, 0));
    beat(bt(9, 1));
    idle();
    chk("t6_pre_valid", 64'(ROW_VALID), 64'd1);
    chk("t6_pre_short", 64'(SHORT_ERR), 64'd1);
    beat(bt(7, 0));
    beat(bt(7, 1));
    BUS_DATA = bt(7, 2);
    #2;
    RESET = 1'b1;
    #1;
    chk_zero("t6_async");
    BUS_STROBE = 1'b0;
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    ROW_READY = 1'b1;
    send_row(7);
    BUS_STROBE = 1'b0;
    chk("t6_valid", 64'(ROW_VALID), 64'd1);
    chk("t6_index", 64'(ROW_INDEX), 64'd0);
    chk("t6_data",  ROW_DATA, mkrow(7));
    chk("t6_fend",  64'(FRAME_END), 64'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_bus_receiver.md
Name: output_bus_receiver

Overview:
- Receiving end of the pixel output bus; sits off-chip or in the host/readout model.
- Accepts binary (already Gray-decoded) pixel beats of OUTPUT_BUS_WIDTH pixels per CLK while BUS_STROBE is high.
- Reassembles full PIXEL_ARRAY_WIDTH rows and tracks row/frame position.
- Hands completed rows to a consumer over a valid/ready handshake, with overflow and short-burst error detection.

Parameters:
PIXEL_ARRAY_WIDTH, 8, pixels per row; must be a multiple of OUTPUT_BUS_WIDTH
PIXEL_ARRAY_HEIGHT, 8, rows per frame
OUTPUT_BUS_WIDTH, 2, pixels per bus beat
PIXEL_BITS, 8, bits per pixel
(derived) BEATS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; BEAT_BITS = max(1,clog2(BEATS)); ROW_BITS = max(1,clog2(PIXEL_ARRAY_HEIGHT))

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
BUS_STROBE  in  1  high = BUS_DATA carries a valid beat this cycle
BUS_DATA  in  OUTPUT_BUS_WIDTH*PIXEL_BITS  beat payload; pixel k of beat at bits [k*PIXEL_BITS +: PIXEL_BITS]
ROW_DATA  out  PIXEL_ARRAY_WIDTH*PIXEL_BITS  assembled row; pixel p at [p*PIXEL_BITS +: PIXEL_BITS]
ROW_VALID  out  1  ROW_DATA/ROW_INDEX/FRAME_END valid
ROW_READY  in  1  consumer accepts the row when ROW_VALID & ROW_READY at a rising edge
ROW_INDEX  out  ROW_BITS  row number within frame of the presented row
FRAME_END  out  1  presented row is the last row of the frame
OVERFLOW  out  1  sticky: a completed row was dropped
SHORT_ERR  out  1  sticky: burst ended before BEATS beats
CLEAR_ERR  in  1  synchronous clear of OVERFLOW and SHORT_ERR

Behaviour:
- Reset (async): all outputs 0, beat counter 0, row counter 0, state IDLE, assembly buffer 0.
- Assembly FSM states are IDLE and RECV.
  - IDLE: BUS_STROBE=1 -> capture beat 0 into pixels [0..OUTPUT_BUS_WIDTH-1], beat counter := 1, go RECV. With BEATS=1, complete immediately and stay IDLE.
  - RECV: BUS_STROBE=1 -> capture beat n into pixels [n*OUTPUT_BUS_WIDTH ..], beat counter +1.
  - Beat BEATS-1 completes the row: beat counter := 0, go IDLE.
  - Strobe held high after completion starts the next row on the following cycle, with no gap required.
  - RECV with BUS_STROBE=0: discard the partial row, set SHORT_ERR, beat counter := 0, go IDLE.
- Row completion is on the edge that samples the last beat.
  - If the output register is empty, or ROW_VALID & ROW_READY on that same edge: load ROW_DATA (last beat merged in), ROW_INDEX := row counter, FRAME_END := (row counter == PIXEL_ARRAY_HEIGHT-1), ROW_VALID := 1. Latency is 1 cycle from the last beat to ROW_VALID.
  - Otherwise: the row is dropped, ROW_DATA holds the old row unchanged, OVERFLOW := 1.
  - In both cases the row counter advances, wrapping to 0 after PIXEL_ARRAY_HEIGHT-1, so frame alignment is kept.
- Handshake: ROW_VALID stays high and ROW_DATA/ROW_INDEX/FRAME_END stay stable until accepted. After acceptance with no new row loaded, ROW_VALID := 0.
- CLEAR_ERR clears the sticky flags. A new error event on the same edge wins: the flag stays 1.
- Partial rows are never presented. ROW_DATA never changes while ROW_VALID=1 and unaccepted.
- RESET mid-burst or mid-handshake aborts immediately. The next row received is row 0.

Test Plan:
1. Defaults (BEATS=4). Strobe 4 cycles with beats {1,0},{3,2},{5,4},{7,6}, ROW_READY=1 -> ROW_VALID=1 one cycle after the 4th beat; ROW_DATA pixels 0..7 = 0..7; ROW_INDEX=0; FRAME_END=0.
2. 8 rows back-to-back with strobe continuously high for 32 cycles, ROW_READY=1 -> 8 single-cycle ROW_VALID pulses with ROW_INDEX 0..7. FRAME_END=1 only with index 7. The next row has index 0.
3. ROW_READY=0 while 2 rows arrive -> first row stays presented and stable; second row dropped; OVERFLOW=1. Raise ROW_READY -> first row accepted, ROW_VALID falls. Next row carries ROW_INDEX=2.
4. Strobe drops after 2 beats -> SHORT_ERR=1, no ROW_VALID. A following full 4-beat burst is presented correctly with ROW_INDEX unchanged. CLEAR_ERR pulse -> SHORT_ERR=0.
5. ROW_READY=1 and a row completing on the same edge a held row is accepted -> new row loaded, ROW_VALID stays 1, OVERFLOW stays 0.
6. RESET asserted asynchronously mid-burst (beat 2) and while ROW_VALID=1 -> all outputs 0 immediately. The next full burst is presented as ROW_INDEX=0.
